// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl
//   Row-multiplexed LED matrix sequencer. Latches a 5-row x 24-bit frame from
//   the pattern generator at the start of each refresh frame. It drives one
//   row at a time, with all-off blanking before every row. After each
//   FRAMES_PER_STEP refresh frames it pulses NextPattern, unless Hold is high.
//
//   Ports
//     clk           rising-edge clock
//     reset         asynchronous active-low reset
//     Enable        scan enable; low returns to IDLE on the next edge
//     Hold          suppresses NextPattern (refresh keeps running)
//     PatternSignal 120-bit frame, row r = bits [119-24r : 96-24r]
//     NextPattern   one-cycle step pulse to the pattern generator
//     RowSel        one-hot row enable (bit r = row r), registered
//     ColData       column data of the selected row, registered
//     FrameDone     one-cycle pulse after the last row of every frame
module pattern_scan_ctrl #(
   parameter int unsigned ROW_TICKS       = 1000,
   parameter int unsigned BLANK_TICKS     = 8,
   parameter int unsigned FRAMES_PER_STEP = 50
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         Enable,
   input  logic         Hold,
   input  logic [119:0] PatternSignal,
   output logic         NextPattern,
   output logic [4:0]   RowSel,
   output logic [23:0]  ColData,
   output logic         FrameDone
);

   localparam int unsigned TickMax = (ROW_TICKS > BLANK_TICKS) ? ROW_TICKS : BLANK_TICKS;
   localparam int unsigned TickW   = (TickMax > 1) ? $clog2(TickMax) : 1;
   localparam int unsigned FcntW   = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

   localparam logic [TickW-1:0] blankLast = TickW'(BLANK_TICKS - 1);
   localparam logic [TickW-1:0] driveLast = TickW'(ROW_TICKS - 1);
   localparam logic [FcntW-1:0] fcntLast  = FcntW'(FRAMES_PER_STEP - 1);

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      DRIVE
   } scanState;

   scanState           state, stateNext;
   logic [2:0]         row, rowNext;
   logic [TickW-1:0]   tick, tickNext;
   logic [FcntW-1:0]   fcnt, fcntNext;
   logic [119:0]       shadow, shadowNext;
   logic               frameEnd;
   logic               stepPulse;
   logic [23:0]        rowData;
   logic [4:0]         rowSelNext;
   logic [23:0]        colDataNext;

   // Next-state logic. Enable low overrides everything, so an aborted frame
   // never reaches its frame end and raises no FrameDone/NextPattern.
   always_comb begin
      stateNext  = state;
      rowNext    = row;
      tickNext   = tick;
      fcntNext   = fcnt;
      shadowNext = shadow;
      frameEnd   = 1'b0;
      stepPulse  = 1'b0;

      if (!Enable) begin
         stateNext = IDLE;
         rowNext   = '0;
         tickNext  = '0;
      end else begin
         case (state)
            IDLE: begin
               stateNext = BLANK;
               rowNext   = '0;
               tickNext  = '0;
            end
            BLANK: begin
               if (tick == blankLast) begin
                  stateNext = DRIVE;
                  tickNext  = '0;
                  if (row == 3'd0) begin
                     shadowNext = PatternSignal;
                  end
               end else begin
                  tickNext = tick + 1'b1;
               end
            end
            DRIVE: begin
               if (tick == driveLast) begin
                  stateNext = BLANK;
                  tickNext  = '0;
                  if (row == 3'd4) begin
                     rowNext  = '0;
                     frameEnd = 1'b1;
                     if ((fcnt == fcntLast) && !Hold) begin
                        stepPulse = 1'b1;
                        fcntNext  = '0;
                     end else if (fcnt != fcntLast) begin
                        fcntNext = fcnt + 1'b1;
                     end
                  end else begin
                     rowNext = row + 3'd1;
                  end
               end else begin
                  tickNext = tick + 1'b1;
               end
            end
            default: begin
               stateNext = IDLE;
               rowNext   = '0;
               tickNext  = '0;
            end
         endcase
      end
   end

   // Outputs are registered from the *next* state. This makes the first DRIVE
   // cycle of row 0 show the frame being latched into the shadow on that same
   // edge.
   always_comb begin
      rowData = '0;
      case (rowNext)
         3'd0:    rowData = shadowNext[119:96];
         3'd1:    rowData = shadowNext[95:72];
         3'd2:    rowData = shadowNext[71:48];
         3'd3:    rowData = shadowNext[47:24];
         3'd4:    rowData = shadowNext[23:0];
         default: rowData = '0;
      endcase

      rowSelNext  = '0;
      colDataNext = '0;
      if (stateNext == DRIVE) begin
         rowSelNext  = 5'b00001 << rowNext;
         colDataNext = rowData;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         row         <= '0;
         tick        <= '0;
         fcnt        <= '0;
         shadow      <= '0;
         RowSel      <= '0;
         ColData     <= '0;
         FrameDone   <= 1'b0;
         NextPattern <= 1'b0;
      end else begin
         state       <= stateNext;
         row         <= rowNext;
         tick        <= tickNext;
         fcnt        <= fcntNext;
         shadow      <= shadowNext;
         RowSel      <= rowSelNext;
         ColData     <= colDataNext;
         FrameDone   <= frameEnd;
         NextPattern <= stepPulse;
      end
   end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl with ROW_TICKS=4, BLANK_TICKS=2,
// FRAMES_PER_STEP=3 (frame = 30 cycles, step = 90 cycles).
// Cycle index k counts samples taken 1 time unit after each rising edge;
// k=0 is the first sample after the edge at which Enable is first seen high.
module tb_pattern_scan_ctrl;

   localparam logic [119:0] P1 = 120'h0000FF_000F0F_000303_00070F_00FFFF;
   localparam logic [119:0] PZ = '0;

   logic         clk = 1'b0;
   logic         reset;
   logic         Enable;
   logic         Hold;
   logic [119:0] PatternSignal;
   logic         NextPattern;
   logic [4:0]   RowSel;
   logic [23:0]  ColData;
   logic         FrameDone;

   int k;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int          k;
      logic [119:0] pat;       // PatternSignal applied after this sample
      logic [4:0]  rowSel;
      logic [23:0] colData;
      logic        frameDone;
      logic        nextPattern;
   } vec_t;

   vec_t vec[24];

   pattern_scan_ctrl #(
      .ROW_TICKS       (4),
      .BLANK_TICKS     (2),
      .FRAMES_PER_STEP (3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .Enable        (Enable),
      .Hold          (Hold),
      .PatternSignal (PatternSignal),
      .NextPattern   (NextPattern),
      .RowSel        (RowSel),
      .ColData       (ColData),
      .FrameDone     (FrameDone)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at k=%0d: got %h expected %h", name, k, act, exp);
      end
   endtask

   task automatic chkIdleOutputs(input string tag);
      chk({tag, "_RowSel"}, 32'(RowSel), 32'h0);
      chk({tag, "_ColData"}, 32'(ColData), 32'h0);
      chk({tag, "_FrameDone"}, 32'(FrameDone), 32'h0);
      chk({tag, "_NextPattern"}, 32'(NextPattern), 32'h0);
   endtask

   initial begin
      // First frame shows P1; PatternSignal is cleared during row 2 so rows
      // 3-4 must still show P1 and the second frame must be all zeros.
      vec[0]  = '{0,  P1, 5'b00000, 24'h000000, 1'b0, 1'b0};
      vec[1]  = '{1,  P1, 5'b00000, 24'h000000, 1'b0, 1'b0};
      vec[2]  = '{2,  P1, 5'b00001, 24'h0000FF, 1'b0, 1'b0};
      vec[3]  = '{5,  P1, 5'b00001, 24'h0000FF, 1'b0, 1'b0};
      vec[4]  = '{6,  P1, 5'b00000, 24'h000000, 1'b0, 1'b0};
      vec[5]  = '{7,  P1, 5'b00000, 24'h000000, 1'b0, 1'b0};
      vec[6]  = '{8,  P1, 5'b00010, 24'h000F0F, 1'b0, 1'b0};
      vec[7]  = '{11, P1, 5'b00010, 24'h000F0F, 1'b0, 1'b0};
      vec[8]  = '{12, P1, 5'b00000, 24'h000000, 1'b0, 1'b0};
      vec[9]  = '{14, P1, 5'b00100, 24'h000303, 1'b0, 1'b0};
      vec[10] = '{15, PZ, 5'b00100, 24'h000303, 1'b0, 1'b0};
      vec[11] = '{17, PZ, 5'b00100, 24'h000303, 1'b0, 1'b0};
      vec[12] = '{18, PZ, 5'b00000, 24'h000000, 1'b0, 1'b0};
      vec[13] = '{20, PZ, 5'b01000, 24'h00070F, 1'b0, 1'b0};
      vec[14] = '{23, PZ, 5'b01000, 24'h00070F, 1'b0, 1'b0};
      vec[15] = '{24, PZ, 5'b00000, 24'h000000, 1'b0, 1'b0};
      vec[16] = '{26, PZ, 5'b10000, 24'h00FFFF, 1'b0, 1'b0};
      vec[17] = '{29, PZ, 5'b10000, 24'h00FFFF, 1'b0, 1'b0};
      vec[18] = '{30, PZ, 5'b00000, 24'h000000, 1'b1, 1'b0};
      vec[19] = '{31, PZ, 5'b00000, 24'h000000, 1'b0, 1'b0};
      vec[20] = '{32, PZ, 5'b00001, 24'h000000, 1'b0, 1'b0};
      vec[21] = '{38, PZ, 5'b00010, 24'h000000, 1'b0, 1'b0};
      vec[22] = '{56, PZ, 5'b10000, 24'h000000, 1'b0, 1'b0};
      vec[23] = '{60, PZ, 5'b00000, 24'h000000, 1'b1, 1'b0};

      reset         = 1'b0;
      Enable        = 1'b0;
      Hold          = 1'b0;
      PatternSignal = P1;
      k             = -100;

      // Power-up reset
      step();
      step();
      step();
      chkIdleOutputs("reset");

      // Release reset and enable together; the next edge is E.
      reset  = 1'b1;
      Enable = 1'b1;
      k      = -1;

      // Scan order, data and tear-free latching
      for (int i = 0; i < 24; i++) begin
         while (k < vec[i].k) step();
         chk("scan_RowSel", 32'(RowSel), 32'(vec[i].rowSel));
         chk("scan_ColData", 32'(ColData), 32'(vec[i].colData));
         chk("scan_FrameDone", 32'(FrameDone), 32'(vec[i].frameDone));
         chk("scan_NextPattern", 32'(NextPattern), 32'(vec[i].nextPattern));
         PatternSignal = vec[i].pat;
      end

      // Free run to k=330, then Hold across the step due at 360, released
      // after the frame end at 390: pulse at 420, then every 90 cycles.
      while (k < 600) begin
         step();
         chk("run_FrameDone", 32'(FrameDone), 32'((k % 30) == 0));
         chk("run_NextPattern", 32'(NextPattern),
             32'(k == 90 || k == 180 || k == 270 || k == 420 || k == 510 || k == 600));
         chk("run_OneHot", 32'($countones(RowSel) <= 1), 32'h1);
         if (k == 330) Hold = 1'b1;
         if (k == 390) Hold = 1'b0;
      end

      // Disable during row 3 of the frame starting at k=630 (fcnt is 1 there)
      while (k < 651) step();
      chk("preDisable_RowSel", 32'(RowSel), 32'b01000);
      Enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chkIdleOutputs("disabled");
      end

      // Re-enable: restart at row 0 BLANK, fcnt continues 1 -> 2 -> step
      PatternSignal = P1;
      Enable        = 1'b1;
      for (int j = 0; j <= 62; j++) begin
         step();
         chk("reen_FrameDone", 32'(FrameDone), 32'(j == 30 || j == 60));
         chk("reen_NextPattern", 32'(NextPattern), 32'(j == 60));
         if (j == 0 || j == 1) chk("reen_blank_RowSel", 32'(RowSel), 32'h0);
         if (j == 2) begin
            chk("reen_first_RowSel", 32'(RowSel), 32'b00001);
            chk("reen_first_ColData", 32'(ColData), 32'h0000FF);
         end
      end
      chk("preReset_RowSel", 32'(RowSel), 32'b00001);

      // Asynchronous reset mid-DRIVE: outputs clear without a clock edge
      #2;
      reset = 1'b0;
      #1;
      chkIdleOutputs("asyncReset");
      step();
      chkIdleOutputs("inReset");
      reset = 1'b1;

      // After reset fcnt is 0 again, so the first step is three frames away
      for (int j = 0; j <= 90; j++) begin
         step();
         chk("postReset_FrameDone", 32'(FrameDone), 32'(j == 30 || j == 60 || j == 90));
         chk("postReset_NextPattern", 32'(NextPattern), 32'(j == 90));
         if (j == 1) chk("postReset_blank_RowSel", 32'(RowSel), 32'h0);
         if (j == 2) begin
            chk("postReset_first_RowSel", 32'(RowSel), 32'b00001);
            chk("postReset_first_ColData", 32'(ColData), 32'h0000FF);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Display sequencer that sits between the 120-bit pattern generator and the LED matrix drivers. It time-multiplexes the current 5-row x 24-bit frame onto one row at a time and inserts blanking between rows. It latches each frame tear-free at frame start. After a programmable number of refresh frames it pulses `NextPattern` to step the pattern generator to its next animation frame.

## Interface
Parameters:
- `ROW_TICKS`, default 1000: clock cycles each row is driven; must be ≥1.
- `BLANK_TICKS`, default 8: clock cycles of all-off blanking before each row; must be ≥2.
- `FRAMES_PER_STEP`, default 50: refresh frames per animation step; must be ≥1.

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `Enable`, in, 1: scan enable; low forces IDLE.
- `Hold`, in, 1: freezes the animation; refresh continues.
- `PatternSignal`, in, 120: frame from the pattern generator. Row r = bits [119-24r : 96-24r], r=0..4.
- `NextPattern`, out, 1: one-cycle step pulse to the pattern generator.
- `RowSel`, out, 5: one-hot row enable; bit r = row r.
- `ColData`, out, 24: column data for the selected row.
- `FrameDone`, out, 1: one-cycle pulse at the end of every refresh frame.

## Operation
- States: IDLE, BLANK, DRIVE. Registers: row index `row` (0..4), tick counter, frame counter `fcnt` (0..FRAMES_PER_STEP-1), shadow frame `shadow` (120 bits).
- Counter widths are sized with $clog2 of their maxima. No wrap is allowed other than the defined ones.
- IDLE:
  - RowSel=0, ColData=0.
  - Rising edge with Enable=1 → BLANK, row=0, tick=0.
- BLANK:
  - RowSel=0, ColData=0, for BLANK_TICKS cycles.
  - On the last BLANK cycle of row 0, `shadow` <= `PatternSignal`.
  - Then → DRIVE with tick=0.
- DRIVE:
  - RowSel has bit `row` set. ColData = shadow row `row`. Held for ROW_TICKS cycles.
  - On the last DRIVE cycle: if row<4 → BLANK, row+1. If row=4 → BLANK, row=0, and this is the frame end.
- Frame end:
  - FrameDone=1 for the next cycle.
  - If fcnt=FRAMES_PER_STEP-1 and Hold=0: NextPattern=1 for the next cycle and fcnt<=0.
  - Otherwise fcnt increments, saturating at FRAMES_PER_STEP-1.
- Hold=1 at a frame end suppresses NextPattern. The pulse is issued at the first subsequent frame end with Hold=0.
- Enable=0 in any state:
  - Next edge → IDLE; RowSel, ColData, row and tick are cleared.
  - `fcnt` and `shadow` are retained.
  - No FrameDone or NextPattern is issued for the aborted frame.
- Re-enable always restarts at row 0 BLANK.
- The shadow is loaded only in row 0 BLANK. PatternSignal changes during a frame never reach ColData until the next frame.

## Timing
- Reset (asynchronous assert):
  - State=IDLE; row, tick, fcnt and shadow = 0.
  - Outputs: NextPattern=0, RowSel=5'b00000, ColData=24'h000000, FrameDone=0.
- Reset release takes effect on the next rising edge.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Enable high sampled at edge E:
  - BLANK begins after E.
  - First DRIVE cycle (RowSel=00001) begins BLANK_TICKS cycles later.
  - ColData in that cycle reflects PatternSignal sampled at the preceding edge.
- Frame period = 5·(BLANK_TICKS+ROW_TICKS) cycles.
- Step period = FRAMES_PER_STEP frame periods when Hold=0.
- NextPattern and FrameDone rise in the same cycle: the first BLANK cycle of row 0.
- NextPattern precedes the shadow load by BLANK_TICKS-1 ≥ 1 cycle, so the pattern generator's response to NextPattern is captured in the following frame.
- At most one row is ever selected. At least BLANK_TICKS all-off cycles separate any two DRIVE periods.

## Test plan
Bench parameters: ROW_TICKS=4, BLANK_TICKS=2, FRAMES_PER_STEP=3 (frame = 30 cycles, step = 90 cycles).
- Reset and enable:
  - Stimulus: reset low mid-DRIVE, then release; Enable=1 at edge E.
  - Required: outputs go to 0 immediately at reset assertion; RowSel=00001 first appears 2 cycles after E.
- Scan order and data:
  - Stimulus: PatternSignal = 120'h0000FF_000F0F_000303_00070F_00FFFF.
  - Required: rows 0..4 each drive 4 cycles with ColData 0000FF, 000F0F, 000303, 00070F, 00FFFF in order; 2 blank cycles (RowSel=0) before each row.
- Tear-free latching:
  - Stimulus: change PatternSignal to 120'h0 during row 2 DRIVE.
  - Required: rows 3–4 still show the old data; the next frame shows all zeros.
- Step pulses:
  - Stimulus: free run for 270 cycles.
  - Required: FrameDone pulses every 30 cycles; NextPattern pulses exactly every 90 cycles, coincident with every third FrameDone, each 1 cycle wide.
- Hold:
  - Stimulus: Hold=1 across a due step, released 2 frames later.
  - Required: no NextPattern while Hold=1; a single pulse at the first frame end after release, then the normal 90-cycle cadence.
- Disable mid-frame:
  - Stimulus: Enable=0 during row 3, then re-enable.
  - Required: next edge gives RowSel=0 and ColData=0, no FrameDone; restart at row 0; fcnt continues from its retained value.
